// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: pointer width and Gray/binary conversion.
// Used by both the write-side full block and the read-side empty block.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int FN_W = 32;

  function automatic int ptr_width(
    input int aw
  );
    return aw + 1;
  endfunction

  function automatic logic [FN_W-1:0] bin2gray(
    input logic [FN_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [FN_W-1:0] gray2bin(
    input logic [FN_W-1:0] g
  );
    logic [FN_W-1:0] b;
    b = g;
    for (int i = 1; i < FN_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write pointer and registered full flag.
// Optional FIFO_WR_LEVEL_EN adds a registered write-side occupancy output.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_inc,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  wr_full,
  output logic                  wr_overflow
`ifdef FIFO_WR_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   wr_level
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  // Full when Gray pointers differ only in their top two bits.
  localparam logic [PW-1:0] FULL_MASK =
    PW'(3) << (PW - 2);

  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic          full_next;

  fifo_sync_2ff #(
    .WIDTH (PW)
  ) u_rsync (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  assign wr_en      = wr_inc & ~wr_full;
  assign wr_addr    = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PW'(wr_en);
  assign wgray_next =
    PW'(bin2gray(FN_W'(wbin_next)));
  assign full_next  =
    (wgray_next == (rq2 ^ FULL_MASK));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      wr_full     <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      wr_full     <= full_next;
      wr_overflow <= wr_inc & wr_full;
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  logic [PW-1:0] rbin_sync;

  assign rbin_sync =
    PW'(gray2bin(FN_W'(rq2)));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_level <= '0;
    end else begin
      wr_level <= wbin_next - rbin_sync;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized self-checking bench for fifo_wptr_full against an occupancy model.
module tb_fifo_wptr_full;

  localparam int AW = 4;
  localparam int PW = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int MOD = 1 << PW;

  logic          wr_clk;
  logic          wr_rst_n;
  logic          wr_inc;
  logic [PW-1:0] rd_ptr_gray;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_ptr_gray;
  logic          wr_full;
  logic          wr_overflow;
`ifdef FIFO_WR_LEVEL_EN
  logic [PW-1:0] wr_level;
`endif

  fifo_wptr_full #(
    .ADDR_WIDTH (AW)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .wr_inc      (wr_inc),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .wr_full     (wr_full),
    .wr_overflow (wr_overflow)
`ifdef FIFO_WR_LEVEL_EN
    ,
    .wr_level    (wr_level)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    int m;
    m = b % MOD;
    return PW'(m ^ (m >> 1));
  endfunction

  function automatic int popcnt(input logic [PW-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < PW; i++) c += int'(v[i]);
    return c;
  endfunction

  // Model: total writes, total reads, and what the writer has seen of reads.
  int m_writes;
  int m_reads;
  int seen1;
  int seen2;
  bit m_full;
  bit m_ovf;
  int m_level;
  logic [PW-1:0] prev_gray;

  task automatic model_reset();
    m_writes = 0;
    m_reads = 0;
    seen1 = 0;
    seen2 = 0;
    m_full = 0;
    m_ovf = 0;
    m_level = 0;
    prev_gray = '0;
  endtask

  task automatic check_regs();
    chk("ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_writes)));
    chk("full", 32'(wr_full), 32'(m_full));
    chk("overflow", 32'(wr_overflow), 32'(m_ovf));
    chk("gray_step", 32'(popcnt(wr_ptr_gray ^ prev_gray) <= 1), 32'd1);
`ifdef FIFO_WR_LEVEL_EN
    chk("level", 32'(wr_level), 32'(m_level));
`endif
    prev_gray = wr_ptr_gray;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit inc, input int reads);
    bit en;
    int occ;
    wr_inc = inc;
    m_reads = reads;
    rd_ptr_gray = to_gray(reads);
    #1;
    en = inc && !m_full;
    chk("wr_en", 32'(wr_en), 32'(en));
    chk("wr_addr", 32'(wr_addr), 32'(m_writes % DEPTH));
    @(posedge wr_clk);
    m_ovf = inc && m_full;
    if (en) m_writes++;
    occ = m_writes - seen2;
    m_full = (occ == DEPTH);
    m_level = occ;
    seen2 = seen1;
    seen1 = reads;
    @(negedge wr_clk);
    check_regs();
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    wr_inc = 1'b0;
    rd_ptr_gray = '0;
    model_reset();
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(negedge wr_clk);
  endtask

  initial begin
    int waited;
    int toggles;
    logic msb_prev;
    wr_rst_n = 1'b0;
    wr_inc = 1'b0;
    rd_ptr_gray = '0;
    do_reset();

    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_gray", 32'(wr_ptr_gray), 32'd0);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_ovf", 32'(wr_overflow), 32'd0);
`ifdef FIFO_WR_LEVEL_EN
    chk("rst_level", 32'(wr_level), 32'd0);
`endif
    repeat (3) cycle(0, 0);

    for (int i = 0; i < DEPTH; i++) cycle(1, 0);
    chk("fill_gray", 32'(wr_ptr_gray), 32'b11000);
    chk("fill_full", 32'(wr_full), 32'd1);

    cycle(1, 0);
    chk("ovf_pulse", 32'(wr_overflow), 32'd1);
    chk("ovf_hold", 32'(wr_ptr_gray), 32'b11000);
    cycle(0, 0);
    chk("ovf_clear", 32'(wr_overflow), 32'd0);

    waited = 0;
    while (wr_full && waited < 8) begin
      cycle(0, 1);
      waited++;
    end
    chk("release_lat", 32'(waited), 32'd3);
    chk("wrap_addr", 32'(wr_addr), 32'd0);
    cycle(1, 1);

    do_reset();
    toggles = 0;
    msb_prev = wr_ptr_gray[PW-1];
    for (int i = 0; i < 40; i++) begin
      cycle(1, m_writes);
      if (wr_ptr_gray[PW-1] != msb_prev) toggles++;
      msb_prev = wr_ptr_gray[PW-1];
      chk("stream_nofull", 32'(wr_full), 32'd0);
    end
    chk("msb_toggles", 32'(toggles), 32'd2);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = m_reads;
      if (r < m_writes && $urandom_range(0, 99) < 40) r++;
      cycle(bit'($urandom_range(0, 99) < 55), r);
    end

    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0);
    wr_inc = 1'b0;
    #2;
    wr_rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_gray", 32'(wr_ptr_gray), 32'd0);
    chk("arst_full", 32'(wr_full), 32'd0);
    chk("arst_ovf", 32'(wr_overflow), 32'd0);
    chk("arst_en", 32'(wr_en), 32'd0);
    wr_inc = 1'b1;
    @(posedge wr_clk);
    #1;
    chk("arst_ignore", 32'(wr_ptr_gray), 32'd0);
    @(negedge wr_clk);
    wr_inc = 1'b0;
    wr_rst_n = 1'b1;
    model_reset();
    @(negedge wr_clk);
    for (int i = 0; i < 5; i++) cycle(1, 0);
    cycle(0, 0);
`ifdef FIFO_WR_LEVEL_EN
    chk("level5", 32'(wr_level), 32'd5);
`endif
    chk("addr5", 32'(wr_addr), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
